// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master arbiter for one shared request/ready bus.
// A winner is granted in IDLE. Its transaction is held on the bus in BUSY
// until i_bus_ready arrives or the optional timeout expires. DONE is a
// one-cycle gap that lets the owner drop its request after the ready pulse.
module bus_arbiter #(
   parameter int FAIR    = 1,   // 1 = round-robin on ties, 0 = master A always wins
   parameter int TIMEOUT = 255  // BUSY cycles without ready before abort, 0 = never
) (
   input  logic        i_clock,
   input  logic        i_reset,
   // master A
   input  logic        i_a_request,
   input  logic        i_a_rw,
   input  logic [31:0] i_a_address,
   input  logic [31:0] i_a_data,
   output logic        o_a_ready,
   output logic        o_a_error,
   output logic [31:0] o_a_data,
   // master B
   input  logic        i_b_request,
   input  logic        i_b_rw,
   input  logic [31:0] i_b_address,
   input  logic [31:0] i_b_data,
   output logic        o_b_ready,
   output logic        o_b_error,
   output logic [31:0] o_b_data,
   // shared bus
   output logic        o_bus_request,
   output logic        o_bus_rw,
   output logic [31:0] o_bus_address,
   output logic [31:0] o_bus_data,
   input  logic        i_bus_ready,
   input  logic [31:0] i_bus_data
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);
   localparam bit         TMO_EN    = (TIMEOUT != 0);
   localparam bit         FAIR_EN   = (FAIR != 0);

   state_t      state_q;
   logic        owner_b_q;   // 1 = B owns the current transaction
   logic        last_b_q;    // 1 = B was granted most recently
   logic [7:0]  cnt_q;
   logic [7:0]  cnt_d;
   logic        tmo_hit_d;
   logic        grant_b_d;

   logic        bus_req_q;
   logic        bus_rw_q;
   logic [31:0] bus_addr_q;
   logic [31:0] bus_wdata_q;
   logic        a_ready_q;
   logic        a_error_q;
   logic [31:0] a_data_q;
   logic        b_ready_q;
   logic        b_error_q;
   logic [31:0] b_data_q;

   // Pick the winner among the current requests; ties go by FAIR.
   always_comb begin
      grant_b_d = 1'b0;
      if (i_b_request && !i_a_request) begin
         grant_b_d = 1'b1;
      end else if (i_a_request && i_b_request && FAIR_EN) begin
         grant_b_d = ~last_b_q;
      end
   end

   // Saturating wait counter and the abort condition it produces.
   always_comb begin
      cnt_d     = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
      tmo_hit_d = TMO_EN && (cnt_d == TMO_LIMIT);
   end

   // Arbitration FSM with all outputs registered.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= IDLE;
         owner_b_q   <= 1'b0;
         last_b_q    <= 1'b1;
         cnt_q       <= 8'd0;
         bus_req_q   <= 1'b0;
         bus_rw_q    <= 1'b0;
         bus_addr_q  <= 32'd0;
         bus_wdata_q <= 32'd0;
         a_ready_q   <= 1'b0;
         a_error_q   <= 1'b0;
         a_data_q    <= 32'd0;
         b_ready_q   <= 1'b0;
         b_error_q   <= 1'b0;
         b_data_q    <= 32'd0;
      end else begin
         case (state_q)
            IDLE: begin
               a_ready_q <= 1'b0;
               a_error_q <= 1'b0;
               b_ready_q <= 1'b0;
               b_error_q <= 1'b0;
               if (i_a_request || i_b_request) begin
                  bus_req_q   <= 1'b1;
                  bus_rw_q    <= grant_b_d ? i_b_rw      : i_a_rw;
                  bus_addr_q  <= grant_b_d ? i_b_address : i_a_address;
                  bus_wdata_q <= grant_b_d ? i_b_data    : i_a_data;
                  owner_b_q   <= grant_b_d;
                  last_b_q    <= grant_b_d;
                  cnt_q       <= 8'd0;
                  state_q     <= BUSY;
               end
            end
            BUSY: begin
               if (i_bus_ready) begin
                  // Ready wins over a coinciding timeout.
                  bus_req_q <= 1'b0;
                  if (owner_b_q) begin
                     b_ready_q <= 1'b1;
                     if (!bus_rw_q) b_data_q <= i_bus_data;
                  end else begin
                     a_ready_q <= 1'b1;
                     if (!bus_rw_q) a_data_q <= i_bus_data;
                  end
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_d;
                  if (tmo_hit_d) begin
                     bus_req_q <= 1'b0;
                     if (owner_b_q) begin
                        b_ready_q <= 1'b1;
                        b_error_q <= 1'b1;
                     end else begin
                        a_ready_q <= 1'b1;
                        a_error_q <= 1'b1;
                     end
                     state_q <= DONE;
                  end
               end
            end
            DONE: begin
               a_ready_q <= 1'b0;
               a_error_q <= 1'b0;
               b_ready_q <= 1'b0;
               b_error_q <= 1'b0;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_bus_request = bus_req_q;
   assign o_bus_rw      = bus_rw_q;
   assign o_bus_address = bus_addr_q;
   assign o_bus_data    = bus_wdata_q;
   assign o_a_ready     = a_ready_q;
   assign o_a_error     = a_error_q;
   assign o_a_data      = a_data_q;
   assign o_b_ready     = b_ready_q;
   assign o_b_error     = b_error_q;
   assign o_b_data      = b_data_q;

endmodule
